trap_controller: RTL
====================

# trap_controller

Machine-mode interrupt and trap-return sequencer for the 5-stage pipeline. It owns the interrupt CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause). It decides when a pending interrupt is taken at the EX-stage instruction boundary, then stalls, drains and flushes the pipeline and redirects fetch. It also sequences `mret` (decoded as `is_mret` by the controller) back to the saved PC.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `MTVEC_RESET`, 32'h0000_0100, reset value of mtvec

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `irq_timer`  in  1  level machine-timer interrupt (cause 7)
- `irq_ext`  in  1  level machine-external interrupt (cause 11)
- `ex_valid`  in  1  EX stage holds a valid, non-bubble instruction
- `ex_pc`  in  XLEN  PC of the EX-stage instruction
- `ex_is_mret`  in  1  EX instruction is `mret` (from controller `is_mret`)
- `mem_busy`  in  1  MEM stage has an outstanding load/store
- `csr_wr`  in  1  CSR write strobe from EX
- `csr_addr`  in  12  CSR address for read/write
- `csr_wdata`  in  XLEN  CSR write data
- `csr_rdata`  out  XLEN  combinational read of `csr_addr`; 0 for unowned addresses
- `owns_csr`  out  1  `csr_addr` is one of 0x300, 0x304, 0x305, 0x341, 0x342, 0x344
- `stall`  out  1  freeze IF/ID/EX
- `flush`  out  1  kill IF/ID/EX contents
- `redirect_en`  out  1  load `redirect_pc` into PC
- `redirect_pc`  out  XLEN  fetch target; 0 when `redirect_en`=0

## Operation
- FSM states: IDLE, DRAIN, ENTER, RETURN.
- `take` = mstatus.MIE & ((mie[11]&irq_ext) | (mie[7]&irq_timer)) & ex_valid.
- Priority: external over timer. `take` over `ex_is_mret`.
- IDLE:
  - On `take`, latch `ex_pc` into mepc_pend and the cause code into cause_pend.
  - Next state: DRAIN if `mem_busy`=1, else ENTER.
  - Else, on `ex_valid & ex_is_mret`, go to RETURN.
- DRAIN: hold until `mem_busy`=0, then go to ENTER.
- ENTER (1 cycle), then IDLE:
  - Asserts flush=1, redirect_en=1, redirect_pc = {mtvec[XLEN-1:2],2'b00}.
  - Updates: mepc←mepc_pend, mcause←{1'b1, cause_pend}, MPIE←MIE, MIE←0.
- RETURN (1 cycle), then IDLE:
  - Asserts flush=1, redirect_en=1, redirect_pc=mepc.
  - Updates: MIE←MPIE, MPIE←1.
- `stall` = (IDLE & (take | (ex_valid & ex_is_mret))) | DRAIN | ENTER | RETURN.
- CSR writes:
  - Accepted only in IDLE with `stall`=0.
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable.
  - mie: only bits 7 and 11 are writable.
  - mepc: bits [1:0] forced to 0.
  - mip (0x344) is read-only.
- mip reads return {irq_ext at bit 11, irq_timer at bit 7}.
- Interrupt lines are level-sensitive. Deasserting an irq in DRAIN does not cancel entry; the latched cause is used.

## Timing
- Reset values:
  - State IDLE; mstatus=0, mie=0, mepc=0, mcause=0, mtvec=MTVEC_RESET.
  - stall=0, flush=0, redirect_en=0, redirect_pc=0.
- Interrupt latency, `mem_busy`=0: `take` at cycle N → ENTER at N+1 (flush/redirect) → IDLE at N+2, with new PC fetched at N+2.
- `mret` latency: detected at N → RETURN at N+1 → IDLE at N+2.
- DRAIN adds exactly one cycle per cycle of `mem_busy`=1.
- stall/flush/redirect outputs are combinational from state (and `take` in IDLE). No output is asserted on the cycle `rst` is sampled high.
- Reset while in DRAIN, ENTER or RETURN: IDLE on the next edge, no CSR update, no redirect.
- CSR write and `take` in the same cycle: the write is dropped, because stall=1.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - mtvec[1:0] is writable, with values 00/01 legal; writes of 1x store 00.
  - When mtvec[1:0]=01, ENTER redirects to base + 4×cause code.
- Not defined: mtvec[1:0] hardwired to 00, and ENTER always redirects to base.

## Test plan
- Reset, then mstatus=0x8, mie=0x80, mtvec=0x200. Raise irq_timer with ex_pc=0x40 → one stall cycle, then flush+redirect_pc=0x200; mepc=0x40, mcause=0x8000_0007, MIE=0, MPIE=1.
- irq_ext and irq_timer both high, mie=0x880 → mcause=0x8000_000B. With `TRAP_VECTORED_EN` and mtvec=0x201 → redirect_pc=0x22C.
- Take interrupt with mem_busy high for 3 cycles → stall held 4 cycles, flush asserted only in cycle 5. mepc equals ex_pc at detection.
- `mret` with mepc=0x40, MPIE=1 → redirect_pc=0x40 one cycle after detect; MIE=1, MPIE=1.
- MIE=0 with irq pending → no stall. CSR write mstatus=0x8 is then accepted, and interrupt entry begins on the next cycle.
- Assert rst during DRAIN → next cycle IDLE, redirect_en=0, mepc and mcause unchanged from reset (0).

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode interrupt entry / mret sequencer that owns the interrupt CSRs.
// Optional build macro TRAP_VECTORED_EN enables vectored mtvec mode (mtvec[1:0]=01).
module trap_controller #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            irq_timer,
   input  logic            irq_ext,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_is_mret,
   input  logic            mem_busy,
   input  logic            csr_wr,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            owns_csr,
   output logic            stall,
   output logic            flush,
   output logic            redirect_en,
   output logic [XLEN-1:0] redirect_pc
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

`ifdef TRAP_VECTORED_EN
   localparam logic [XLEN-1:0] MTVEC_RST_VAL = MTVEC_RESET;
`else
   localparam logic [XLEN-1:0] MTVEC_RST_VAL = {MTVEC_RESET[XLEN-1:2], 2'b00};
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ENTER, ST_RETURN} state_t;

   state_t          state_q, state_d;
   logic            mstatus_mie_q, mstatus_mie_d;
   logic            mpie_q, mpie_d;
   logic            mie_tmr_q, mie_tmr_d;
   logic            mie_ext_q, mie_ext_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mepc_pend_q, mepc_pend_d;
   logic [3:0]      cause_pend_q, cause_pend_d;

   logic            ext_en, tmr_en, take;
   logic [XLEN-1:0] trap_base, enter_pc;

   assign ext_en    = mie_ext_q & irq_ext;
   assign tmr_en    = mie_tmr_q & irq_timer;
   assign take      = mstatus_mie_q & (ext_en | tmr_en) & ex_valid;
   assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   assign enter_pc = (mtvec_q[1:0] == 2'b01)
                   ? trap_base + {{(XLEN-6){1'b0}}, cause_pend_q, 2'b00}
                   : trap_base;
`else
   assign enter_pc = trap_base;
`endif

   always_comb begin
      owns_csr  = 1'b1;
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS: csr_rdata = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mstatus_mie_q, 3'b000};
         CSR_MIE:     csr_rdata = {{(XLEN-12){1'b0}}, mie_ext_q, 3'b000, mie_tmr_q, 7'b0};
         CSR_MTVEC:   csr_rdata = mtvec_q;
         CSR_MEPC:    csr_rdata = mepc_q;
         CSR_MCAUSE:  csr_rdata = mcause_q;
         CSR_MIP:     csr_rdata = {{(XLEN-12){1'b0}}, irq_ext, 3'b000, irq_timer, 7'b0};
         default:     owns_csr  = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mstatus_mie_d = mstatus_mie_q;
      mpie_d        = mpie_q;
      mie_tmr_d     = mie_tmr_q;
      mie_ext_d     = mie_ext_q;
      mtvec_d       = mtvec_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mepc_pend_d   = mepc_pend_q;
      cause_pend_d  = cause_pend_q;
      stall         = 1'b0;
      flush         = 1'b0;
      redirect_en   = 1'b0;
      redirect_pc   = '0;

      case (state_q)
         ST_IDLE: begin
            if (take) begin
               stall        = 1'b1;
               mepc_pend_d  = ex_pc;
               cause_pend_d = ext_en ? 4'd11 : 4'd7;
               state_d      = mem_busy ? ST_DRAIN : ST_ENTER;
            end else if (ex_valid && ex_is_mret) begin
               stall   = 1'b1;
               state_d = ST_RETURN;
            end else if (csr_wr) begin
               // CSR writes only land on an unstalled boundary
               case (csr_addr)
                  CSR_MSTATUS: begin
                     mstatus_mie_d = csr_wdata[3];
                     mpie_d        = csr_wdata[7];
                  end
                  CSR_MIE: begin
                     mie_tmr_d = csr_wdata[7];
                     mie_ext_d = csr_wdata[11];
                  end
`ifdef TRAP_VECTORED_EN
                  CSR_MTVEC:  mtvec_d = {csr_wdata[XLEN-1:2], csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
`else
                  CSR_MTVEC:  mtvec_d = {csr_wdata[XLEN-1:2], 2'b00};
`endif
                  CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
                  CSR_MCAUSE: mcause_d = csr_wdata;
                  default: ;
               endcase
            end
         end
         ST_DRAIN: begin
            stall = 1'b1;
            if (!mem_busy) state_d = ST_ENTER;
         end
         ST_ENTER: begin
            stall         = 1'b1;
            flush         = 1'b1;
            redirect_en   = 1'b1;
            redirect_pc   = enter_pc;
            mepc_d        = mepc_pend_q;
            mcause_d      = {1'b1, {(XLEN-5){1'b0}}, cause_pend_q};
            mpie_d        = mstatus_mie_q;
            mstatus_mie_d = 1'b0;
            state_d       = ST_IDLE;
         end
         ST_RETURN: begin
            stall         = 1'b1;
            flush         = 1'b1;
            redirect_en   = 1'b1;
            redirect_pc   = mepc_q;
            mstatus_mie_d = mpie_q;
            mpie_d        = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // pipeline control stays quiet while reset is being sampled
      if (rst) begin
         stall       = 1'b0;
         flush       = 1'b0;
         redirect_en = 1'b0;
         redirect_pc = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mstatus_mie_q <= 1'b0;
         mpie_q        <= 1'b0;
         mie_tmr_q     <= 1'b0;
         mie_ext_q     <= 1'b0;
         mtvec_q       <= MTVEC_RST_VAL;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mepc_pend_q   <= '0;
         cause_pend_q  <= '0;
      end else begin
         state_q       <= state_d;
         mstatus_mie_q <= mstatus_mie_d;
         mpie_q        <= mpie_d;
         mie_tmr_q     <= mie_tmr_d;
         mie_ext_q     <= mie_ext_d;
         mtvec_q       <= mtvec_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mepc_pend_q   <= mepc_pend_d;
         cause_pend_q  <= cause_pend_d;
      end
   end

endmodule
